// File: rtl/ddr3_bypass_arbiter.sv
// Two-port AXI4 read arbiter sharing the DDR3 bypass fast-path read port.
// Optional round-robin tie-break when DDR3_ARB_FAIR_EN is defined; fixed priority (port 0) otherwise.
module ddr3_bypass_arbiter #(
    parameter int WIDTH     = 32,
    parameter int REQID     = 4,
    parameter int ADDRS     = 23,
    parameter int BEATS_MAX = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             s0_arvalid_i,
    output logic             s0_arready_o,
    input  logic [ADDRS-1:0] s0_araddr_i,
    input  logic [REQID-1:0] s0_arid_i,
    input  logic [7:0]       s0_arlen_i,
    input  logic [1:0]       s0_arburst_i,
    input  logic             s0_rready_i,
    output logic             s0_rvalid_o,
    output logic             s0_rlast_o,
    output logic [1:0]       s0_rresp_o,
    output logic [REQID-1:0] s0_rid_o,
    output logic [WIDTH-1:0] s0_rdata_o,
    input  logic             s1_arvalid_i,
    output logic             s1_arready_o,
    input  logic [ADDRS-1:0] s1_araddr_i,
    input  logic [REQID-1:0] s1_arid_i,
    input  logic [7:0]       s1_arlen_i,
    input  logic [1:0]       s1_arburst_i,
    input  logic             s1_rready_i,
    output logic             s1_rvalid_o,
    output logic             s1_rlast_o,
    output logic [1:0]       s1_rresp_o,
    output logic [REQID-1:0] s1_rid_o,
    output logic [WIDTH-1:0] s1_rdata_o,
    output logic             axi_arvalid_o,
    input  logic             axi_arready_i,
    output logic [ADDRS-1:0] axi_araddr_o,
    output logic [REQID-1:0] axi_arid_o,
    output logic [7:0]       axi_arlen_o,
    output logic [1:0]       axi_arburst_o,
    output logic             axi_rready_o,
    input  logic             axi_rvalid_i,
    input  logic             axi_rlast_i,
    input  logic [1:0]       axi_rresp_i,
    input  logic [REQID-1:0] axi_rid_i,
    input  logic [WIDTH-1:0] axi_rdata_i,
    output logic             err_o,
    output logic [1:0]       gnt_o
);

    localparam int CW = $clog2(BEATS_MAX) + 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS_MAX - 1);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t          r_state, w_next;
    logic [1:0]      r_gnt, w_gntNext, w_winner;
    logic            r_err, w_errNext;
    logic [CW-1:0]   r_beat, w_beatNext;
    logic            w_sel, w_selArvalid, w_selRready;
    logic            w_elig0, w_elig1, w_dataPhase;

    assign w_elig0      = s0_arvalid_i & s0_rready_i;
    assign w_elig1      = s1_arvalid_i & s1_rready_i;
    assign w_sel        = r_gnt[1];
    assign w_selArvalid = w_sel ? s1_arvalid_i : s0_arvalid_i;
    assign w_selRready  = w_sel ? s1_rready_i  : s0_rready_i;
    assign w_dataPhase  = (r_state == DATA);

`ifdef DDR3_ARB_FAIR_EN
    logic r_last, w_lastNext;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_last <= 1'b1;
        else       r_last <= w_lastNext;
    end
`endif

    always_comb begin
        w_winner = 2'b00;
        if (w_elig0 & w_elig1) begin
`ifdef DDR3_ARB_FAIR_EN
            w_winner = r_last ? 2'b01 : 2'b10;
`else
            w_winner = 2'b01;
`endif
        end else if (w_elig0) begin
            w_winner = 2'b01;
        end else if (w_elig1) begin
            w_winner = 2'b10;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_gnt   <= 2'b00;
            r_err   <= 1'b0;
            r_beat  <= '0;
        end else begin
            r_state <= w_next;
            r_gnt   <= w_gntNext;
            r_err   <= w_errNext;
            r_beat  <= w_beatNext;
        end
    end

    // The bypass cannot stall, so every valid beat in DATA counts and RLAST always ends the burst.
    always_comb begin
        w_next     = r_state;
        w_gntNext  = r_gnt;
        w_errNext  = r_err;
        w_beatNext = r_beat;
`ifdef DDR3_ARB_FAIR_EN
        w_lastNext = r_last;
`endif
        case (r_state)
            IDLE: begin
                if (axi_rvalid_i) w_errNext = 1'b1;
                if (w_winner != 2'b00) begin
                    w_gntNext = w_winner;
                    w_next    = ADDR;
                end
            end
            ADDR: begin
                if (axi_rvalid_i) w_errNext = 1'b1;
                if (axi_arready_i) begin
                    w_beatNext = '0;
                    w_next     = DATA;
                end else if (!w_selArvalid) begin
                    w_errNext = 1'b1;
                    w_gntNext = 2'b00;
                    w_next    = IDLE;
                end
            end
            DATA: begin
                if (axi_rvalid_i) begin
                    w_beatNext = r_beat + CW'(1);
                    if (!w_selRready) w_errNext = 1'b1;
                    if (axi_rlast_i) begin
                        if (r_beat != LAST_BEAT) w_errNext = 1'b1;
                        w_gntNext = 2'b00;
                        w_next    = IDLE;
`ifdef DDR3_ARB_FAIR_EN
                        w_lastNext = w_sel;
`endif
                    end else if (r_beat == LAST_BEAT) begin
                        w_errNext = 1'b1;
                    end
                end
            end
            default: begin
                w_gntNext = 2'b00;
                w_next    = IDLE;
            end
        endcase
    end

    assign gnt_o         = r_gnt;
    assign err_o         = r_err;
    assign axi_arvalid_o = (r_state == ADDR);
    assign axi_araddr_o  = w_sel ? s1_araddr_i  : s0_araddr_i;
    assign axi_arid_o    = w_sel ? s1_arid_i    : s0_arid_i;
    assign axi_arlen_o   = w_sel ? s1_arlen_i   : s0_arlen_i;
    assign axi_arburst_o = w_sel ? s1_arburst_i : s0_arburst_i;
    assign axi_rready_o  = (r_state != IDLE) & w_selRready;

    assign s0_arready_o  = (r_state == ADDR) & r_gnt[0] & axi_arready_i;
    assign s1_arready_o  = (r_state == ADDR) & r_gnt[1] & axi_arready_i;

    assign s0_rvalid_o   = w_dataPhase & r_gnt[0] & axi_rvalid_i;
    assign s0_rlast_o    = w_dataPhase & r_gnt[0] & axi_rlast_i;
    assign s0_rresp_o    = axi_rresp_i;
    assign s0_rid_o      = axi_rid_i;
    assign s0_rdata_o    = axi_rdata_i;
    assign s1_rvalid_o   = w_dataPhase & r_gnt[1] & axi_rvalid_i;
    assign s1_rlast_o    = w_dataPhase & r_gnt[1] & axi_rlast_i;
    assign s1_rresp_o    = axi_rresp_i;
    assign s1_rid_o      = axi_rid_i;
    assign s1_rdata_o    = axi_rdata_i;

endmodule

// File: tb/tb_ddr3_bypass_arbiter.sv
// Directed self-checking bench for ddr3_bypass_arbiter; expected grant order follows DDR3_ARB_FAIR_EN.
module tb_ddr3_bypass_arbiter;

    localparam int WIDTH = 32;
    localparam int REQID = 4;
    localparam int ADDRS = 23;

    logic             clock = 1'b0;
    logic             reset;
    logic             s0_arvalid_i, s0_arready_o, s0_rready_i, s0_rvalid_o, s0_rlast_o;
    logic [ADDRS-1:0] s0_araddr_i;
    logic [REQID-1:0] s0_arid_i, s0_rid_o;
    logic [7:0]       s0_arlen_i;
    logic [1:0]       s0_arburst_i, s0_rresp_o;
    logic [WIDTH-1:0] s0_rdata_o;
    logic             s1_arvalid_i, s1_arready_o, s1_rready_i, s1_rvalid_o, s1_rlast_o;
    logic [ADDRS-1:0] s1_araddr_i;
    logic [REQID-1:0] s1_arid_i, s1_rid_o;
    logic [7:0]       s1_arlen_i;
    logic [1:0]       s1_arburst_i, s1_rresp_o;
    logic [WIDTH-1:0] s1_rdata_o;
    logic             axi_arvalid_o, axi_arready_i, axi_rready_o, axi_rvalid_i, axi_rlast_i;
    logic [ADDRS-1:0] axi_araddr_o;
    logic [REQID-1:0] axi_arid_o, axi_rid_i;
    logic [7:0]       axi_arlen_o;
    logic [1:0]       axi_arburst_o, axi_rresp_i;
    logic [WIDTH-1:0] axi_rdata_i;
    logic             err_o;
    logic [1:0]       gnt_o;

    int checkCount = 0;
    int passCount  = 0;

    ddr3_bypass_arbiter dut (
        .clock(clock), .reset(reset),
        .s0_arvalid_i(s0_arvalid_i), .s0_arready_o(s0_arready_o), .s0_araddr_i(s0_araddr_i),
        .s0_arid_i(s0_arid_i), .s0_arlen_i(s0_arlen_i), .s0_arburst_i(s0_arburst_i),
        .s0_rready_i(s0_rready_i), .s0_rvalid_o(s0_rvalid_o), .s0_rlast_o(s0_rlast_o),
        .s0_rresp_o(s0_rresp_o), .s0_rid_o(s0_rid_o), .s0_rdata_o(s0_rdata_o),
        .s1_arvalid_i(s1_arvalid_i), .s1_arready_o(s1_arready_o), .s1_araddr_i(s1_araddr_i),
        .s1_arid_i(s1_arid_i), .s1_arlen_i(s1_arlen_i), .s1_arburst_i(s1_arburst_i),
        .s1_rready_i(s1_rready_i), .s1_rvalid_o(s1_rvalid_o), .s1_rlast_o(s1_rlast_o),
        .s1_rresp_o(s1_rresp_o), .s1_rid_o(s1_rid_o), .s1_rdata_o(s1_rdata_o),
        .axi_arvalid_o(axi_arvalid_o), .axi_arready_i(axi_arready_i), .axi_araddr_o(axi_araddr_o),
        .axi_arid_o(axi_arid_o), .axi_arlen_o(axi_arlen_o), .axi_arburst_o(axi_arburst_o),
        .axi_rready_o(axi_rready_o), .axi_rvalid_i(axi_rvalid_i), .axi_rlast_i(axi_rlast_i),
        .axi_rresp_i(axi_rresp_i), .axi_rid_i(axi_rid_i), .axi_rdata_i(axi_rdata_i),
        .err_o(err_o), .gnt_o(gnt_o)
    );

    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, wanted $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyReset();
        reset         = 1'b1;
        s0_arvalid_i  = 0; s0_araddr_i = '0; s0_arid_i = '0; s0_arlen_i = '0; s0_arburst_i = '0; s0_rready_i = 0;
        s1_arvalid_i  = 0; s1_araddr_i = '0; s1_arid_i = '0; s1_arlen_i = '0; s1_arburst_i = '0; s1_rready_i = 0;
        axi_arready_i = 1'b1;
        axi_rvalid_i  = 0; axi_rlast_i = 0; axi_rresp_i = '0; axi_rid_i = '0; axi_rdata_i = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic request(input int port, input logic [ADDRS-1:0] addr, input logic [REQID-1:0] id);
        if (port == 0) begin
            s0_arvalid_i = 1; s0_rready_i = 1; s0_araddr_i = addr; s0_arid_i = id; s0_arlen_i = 8'd3; s0_arburst_i = 2'b01;
        end else begin
            s1_arvalid_i = 1; s1_rready_i = 1; s1_araddr_i = addr; s1_arid_i = id; s1_arlen_i = 8'd3; s1_arburst_i = 2'b01;
        end
    endtask

    // Drives n beats (RLAST on the last one) and checks they reach only the granted port.
    task automatic sendBeats(input int port, input int n);
        logic [WIDTH-1:0] d;
        for (int i = 0; i < n; i++) begin
            d = 32'hCAFE_0000 | (port << 8) | i;
            axi_rvalid_i = 1; axi_rdata_i = d; axi_rlast_i = (i == n - 1); axi_rid_i = 4'(port + 2);
            #1;
            checkCount++;
            if (port == 0) begin
                if (s0_rvalid_o !== 1'b1 || s1_rvalid_o !== 1'b0 || s0_rdata_o !== d || s0_rlast_o !== (i == n - 1))
                    $display("[TB] FAIL beat_route p0 beat %0d: v0=%b v1=%b data=%h last=%b, wanted 1 0 %h %b",
                             i, s0_rvalid_o, s1_rvalid_o, s0_rdata_o, s0_rlast_o, d, (i == n - 1));
                else passCount++;
            end else begin
                if (s1_rvalid_o !== 1'b1 || s0_rvalid_o !== 1'b0 || s1_rdata_o !== d || s1_rlast_o !== (i == n - 1))
                    $display("[TB] FAIL beat_route p1 beat %0d: v1=%b v0=%b data=%h last=%b, wanted 1 0 %h %b",
                             i, s1_rvalid_o, s0_rvalid_o, s1_rdata_o, s1_rlast_o, d, (i == n - 1));
                else passCount++;
            end
            tick();
        end
        axi_rvalid_i = 0; axi_rlast_i = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        checkCount++;
        if (gnt_o !== 2'b00 || err_o !== 1'b0 || axi_arvalid_o !== 1'b0 || s0_arready_o !== 1'b0 ||
            s1_arready_o !== 1'b0 || s0_rvalid_o !== 1'b0 || s1_rvalid_o !== 1'b0)
            $display("[TB] FAIL reset_state: gnt=%b err=%b arv=%b ar0=%b ar1=%b rv0=%b rv1=%b, wanted all 0",
                     gnt_o, err_o, axi_arvalid_o, s0_arready_o, s1_arready_o, s0_rvalid_o, s1_rvalid_o);
        else passCount++;
        applyReset();
    endtask

    task automatic test_port0();
        request(0, 23'h000123, 4'd3);
        checkCount++;
        if (gnt_o !== 2'b00 || axi_arvalid_o !== 1'b0)
            $display("[TB] FAIL p0_latency: gnt=%b arvalid=%b, wanted 00 0", gnt_o, axi_arvalid_o);
        else passCount++;
        tick();
        checkCount++;
        if (gnt_o !== 2'b01 || axi_arvalid_o !== 1'b1 || axi_araddr_o !== 23'h000123 || axi_arid_o !== 4'd3 ||
            axi_arlen_o !== 8'd3 || s0_arready_o !== 1'b1 || s1_arready_o !== 1'b0)
            $display("[TB] FAIL p0_addr: gnt=%b arv=%b addr=%h id=%h len=%h ar0=%b ar1=%b, wanted 01 1 000123 3 03 1 0",
                     gnt_o, axi_arvalid_o, axi_araddr_o, axi_arid_o, axi_arlen_o, s0_arready_o, s1_arready_o);
        else passCount++;
        tick();
        s0_arvalid_i = 0;
        checkCount++;
        if (axi_arvalid_o !== 1'b0 || gnt_o !== 2'b01 || axi_rready_o !== 1'b1)
            $display("[TB] FAIL p0_data_enter: arv=%b gnt=%b rready=%b, wanted 0 01 1", axi_arvalid_o, gnt_o, axi_rready_o);
        else passCount++;
        sendBeats(0, 4);
        checkCount++;
        if (gnt_o !== 2'b00 || err_o !== 1'b0 || s0_rvalid_o !== 1'b0 || axi_rready_o !== 1'b0)
            $display("[TB] FAIL p0_done: gnt=%b err=%b rv0=%b rready=%b, wanted 00 0 0 0", gnt_o, err_o, s0_rvalid_o, axi_rready_o);
        else passCount++;
    endtask

    task automatic test_arbitration();
        logic [1:0] expGnt [3];
`ifdef DDR3_ARB_FAIR_EN
        expGnt = '{2'b01, 2'b10, 2'b01};
`else
        expGnt = '{2'b01, 2'b01, 2'b01};
`endif
        applyReset();
        request(0, 23'h000200, 4'd1);
        request(1, 23'h000300, 4'd2);
        for (int r = 0; r < 3; r++) begin
            tick();
            checkCount++;
            if (gnt_o !== expGnt[r])
                $display("[TB] FAIL arb_round%0d: gnt=%b, wanted %b", r, gnt_o, expGnt[r]);
            else passCount++;
            tick();
            sendBeats(expGnt[r][1] ? 1 : 0, 4);
            checkCount++;
            if (gnt_o !== 2'b00)
                $display("[TB] FAIL arb_idle%0d: gnt=%b, wanted 00", r, gnt_o);
            else passCount++;
        end
        s0_arvalid_i = 0;
        s1_arvalid_i = 0;
        s0_rready_i  = 0;
    endtask

    task automatic test_rready_gate();
        s1_arvalid_i = 1; s1_rready_i = 0; s1_araddr_i = 23'h000444; s1_arid_i = 4'd5; s1_arlen_i = 8'd3;
        for (int c = 0; c < 3; c++) begin
            tick();
            checkCount++;
            if (gnt_o !== 2'b00)
                $display("[TB] FAIL gate_cycle%0d: gnt=%b, wanted 00", c, gnt_o);
            else passCount++;
        end
        s1_rready_i = 1;
        tick();
        checkCount++;
        if (gnt_o !== 2'b10 || axi_araddr_o !== 23'h000444 || axi_arid_o !== 4'd5 || s1_arready_o !== 1'b1 || s0_arready_o !== 1'b0)
            $display("[TB] FAIL gate_grant: gnt=%b addr=%h id=%h ar1=%b ar0=%b, wanted 10 000444 5 1 0",
                     gnt_o, axi_araddr_o, axi_arid_o, s1_arready_o, s0_arready_o);
        else passCount++;
        tick();
        s1_arvalid_i = 0;
        sendBeats(1, 4);
        checkCount++;
        if (gnt_o !== 2'b00 || err_o !== 1'b0)
            $display("[TB] FAIL gate_done: gnt=%b err=%b, wanted 00 0", gnt_o, err_o);
        else passCount++;
    endtask

    task automatic test_stall();
        request(0, 23'h000500, 4'd7);
        tick();
        tick();
        s0_arvalid_i = 0;
        axi_rvalid_i = 1; axi_rlast_i = 0; axi_rdata_i = 32'h1111_0000;
        tick();
        s0_rready_i = 0;
        #1;
        checkCount++;
        if (err_o !== 1'b0 || axi_rready_o !== 1'b0)
            $display("[TB] FAIL stall_pre: err=%b rready=%b, wanted 0 0", err_o, axi_rready_o);
        else passCount++;
        tick();
        s0_rready_i = 1;
        checkCount++;
        if (err_o !== 1'b1)
            $display("[TB] FAIL stall_err: err=%b, wanted 1", err_o);
        else passCount++;
        tick();
        axi_rlast_i = 1;
        tick();
        axi_rvalid_i = 0; axi_rlast_i = 0;
        checkCount++;
        if (gnt_o !== 2'b00 || err_o !== 1'b1)
            $display("[TB] FAIL stall_end: gnt=%b err=%b, wanted 00 1", gnt_o, err_o);
        else passCount++;
        tick();
        checkCount++;
        if (err_o !== 1'b1)
            $display("[TB] FAIL stall_sticky: err=%b, wanted 1", err_o);
        else passCount++;
    endtask

    task automatic test_short_burst();
        applyReset();
        checkCount++;
        if (err_o !== 1'b0)
            $display("[TB] FAIL short_clear: err=%b, wanted 0", err_o);
        else passCount++;
        request(0, 23'h000600, 4'd1);
        tick();
        tick();
        s0_arvalid_i = 0;
        sendBeats(0, 3);
        checkCount++;
        if (gnt_o !== 2'b00 || err_o !== 1'b1)
            $display("[TB] FAIL short_end: gnt=%b err=%b, wanted 00 1", gnt_o, err_o);
        else passCount++;
        request(1, 23'h000700, 4'd9);
        tick();
        checkCount++;
        if (gnt_o !== 2'b10 || axi_araddr_o !== 23'h000700)
            $display("[TB] FAIL short_next: gnt=%b addr=%h, wanted 10 000700", gnt_o, axi_araddr_o);
        else passCount++;
        tick();
        s1_arvalid_i = 0;
        sendBeats(1, 4);
        checkCount++;
        if (gnt_o !== 2'b00 || err_o !== 1'b1)
            $display("[TB] FAIL short_next_done: gnt=%b err=%b, wanted 00 1", gnt_o, err_o);
        else passCount++;
    endtask

    task automatic test_reset_mid_burst();
        applyReset();
        request(0, 23'h000800, 4'd2);
        tick();
        tick();
        s0_arvalid_i = 0;
        axi_rvalid_i = 1;
        tick();
        tick();
        checkCount++;
        if (s0_rvalid_o !== 1'b1 || gnt_o !== 2'b01)
            $display("[TB] FAIL mid_beat2: rv0=%b gnt=%b, wanted 1 01", s0_rvalid_o, gnt_o);
        else passCount++;
        reset = 1'b1;
        #1;
        checkCount++;
        if (gnt_o !== 2'b00 || s0_rvalid_o !== 1'b0 || s1_rvalid_o !== 1'b0 || axi_arvalid_o !== 1'b0 ||
            s0_arready_o !== 1'b0 || s1_arready_o !== 1'b0 || axi_rready_o !== 1'b0 || err_o !== 1'b0)
            $display("[TB] FAIL mid_async: gnt=%b rv0=%b rv1=%b arv=%b ar0=%b ar1=%b rr=%b err=%b, wanted all 0",
                     gnt_o, s0_rvalid_o, s1_rvalid_o, axi_arvalid_o, s0_arready_o, s1_arready_o, axi_rready_o, err_o);
        else passCount++;
        axi_rvalid_i = 0;
        tick();
        reset = 1'b0;
        request(1, 23'h000900, 4'd4);
        tick();
        checkCount++;
        if (gnt_o !== 2'b10 || axi_arvalid_o !== 1'b1 || axi_araddr_o !== 23'h000900 || axi_arid_o !== 4'd4)
            $display("[TB] FAIL mid_regrant: gnt=%b arv=%b addr=%h id=%h, wanted 10 1 000900 4",
                     gnt_o, axi_arvalid_o, axi_araddr_o, axi_arid_o);
        else passCount++;
        tick();
        s1_arvalid_i = 0;
        sendBeats(1, 4);
        checkCount++;
        if (gnt_o !== 2'b00 || err_o !== 1'b0)
            $display("[TB] FAIL mid_done: gnt=%b err=%b, wanted 00 0", gnt_o, err_o);
        else passCount++;
    endtask

    initial begin
        applyReset();
        test_reset();
        test_port0();
        test_arbitration();
        test_rready_gate();
        test_stall();
        test_short_burst();
        test_reset_mid_burst();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
